// File: rtl/pep_ks_ctrl_loop_sched.sv
// KS feed command scheduler: expands batch requests into BCOL_NB column-loop
// commands, interleaved round-robin across slots and throttled by per-slot credits.
module pep_ks_ctrl_loop_sched #(
  parameter int BATCH_NB     = 2,
  parameter int BCOL_NB      = 8,
  parameter int PID_W        = 6,
  parameter int PBS_CNT_W    = 4,
  parameter int MAX_INFLIGHT = 2,
  localparam int BATCH_W     = (BATCH_NB > 1) ? $clog2(BATCH_NB) : 1,
  localparam int LOOP_W      = $clog2(BCOL_NB),
  localparam int CRED_W      = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 s_rst_n,
  input  logic                 reset_cache,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [BATCH_W-1:0]   req_batch_id,
  input  logic [PID_W-1:0]     req_first_pid,
  input  logic [PBS_CNT_W:0]   req_pbs_nb,
  output logic                 pcmd_vld,
  input  logic                 pcmd_rdy,
  output logic [BATCH_W-1:0]   pcmd_batch_id,
  output logic [BATCH_NB-1:0]  pcmd_batch_id_1h,
  output logic [PID_W-1:0]     pcmd_first_pid,
  output logic [PBS_CNT_W-1:0] pcmd_pbs_cnt_max,
  output logic [LOOP_W-1:0]    pcmd_ks_loop,
  input  logic                 loop_done,
  input  logic [BATCH_W-1:0]   loop_done_batch_id,
  output logic                 batch_done,
  output logic [BATCH_W-1:0]   batch_done_batch_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } slot_st_e;

  slot_st_e             st_q   [BATCH_NB];
  slot_st_e             st_d   [BATCH_NB];
  logic [PID_W-1:0]     pid_q  [BATCH_NB];
  logic [PID_W-1:0]     pid_d  [BATCH_NB];
  logic [PBS_CNT_W-1:0] cmax_q [BATCH_NB];
  logic [PBS_CNT_W-1:0] cmax_d [BATCH_NB];
  logic [LOOP_W-1:0]    icnt_q [BATCH_NB];
  logic [LOOP_W-1:0]    icnt_d [BATCH_NB];
  logic [LOOP_W-1:0]    dcnt_q [BATCH_NB];
  logic [LOOP_W-1:0]    dcnt_d [BATCH_NB];
  logic [CRED_W-1:0]    cred_q [BATCH_NB];
  logic [CRED_W-1:0]    cred_d [BATCH_NB];

  logic [BATCH_W-1:0]   rr_q, rr_d;
  logic                 reset_loop_q;

  logic                 vld_q, vld_d;
  logic [BATCH_W-1:0]   bid_q, bid_d;
  logic [PID_W-1:0]     opid_q, opid_d;
  logic [PBS_CNT_W-1:0] ocmax_q, ocmax_d;
  logic [LOOP_W-1:0]    oloop_q, oloop_d;
  logic                 bdone_q, bdone_d;
  logic [BATCH_W-1:0]   bdone_id_q, bdone_id_d;

  logic                 req_slot_idle;
  logic                 req_fire;
  logic [BATCH_NB-1:0]  elig;
  logic                 found;
  logic [BATCH_W-1:0]   win;
  logic                 out_free;
  logic                 load;
  logic                 bypass;
  logic                 ld_hit;
  logic                 ld_load;
  int                   idx;

  always_comb begin
    req_slot_idle = 1'b0;
    for (int i = 0; i < BATCH_NB; i++) begin
      if (req_batch_id == BATCH_W'(i)) req_slot_idle = (st_q[i] == ST_IDLE);
    end
    req_rdy  = req_slot_idle & ~reset_loop_q & s_rst_n;
    req_fire = req_vld & req_rdy;

    // A slot being requested this cycle is eligible at once, so its first
    // command can be registered in the same cycle as the request handshake.
    for (int i = 0; i < BATCH_NB; i++) begin
      elig[i] = ((st_q[i] == ST_ISSUE) && (cred_q[i] != '0)) ||
                (req_fire && (req_batch_id == BATCH_W'(i)));
    end

    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < BATCH_NB; k++) begin
      idx = (int'(rr_q) + k) % BATCH_NB;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = BATCH_W'(idx);
      end
    end

    out_free = ~vld_q | pcmd_rdy;
    load     = out_free & found & ~reset_loop_q;
    bypass   = req_fire && (req_batch_id == win);

    vld_d   = vld_q;
    bid_d   = bid_q;
    opid_d  = opid_q;
    ocmax_d = ocmax_q;
    oloop_d = oloop_q;
    rr_d    = rr_q;
    if (load) begin
      vld_d   = 1'b1;
      bid_d   = win;
      oloop_d = '0;
      rr_d    = (win == BATCH_W'(BATCH_NB - 1)) ? '0 : win + BATCH_W'(1);
      if (bypass) begin
        opid_d  = req_first_pid;
        ocmax_d = PBS_CNT_W'(req_pbs_nb - 1);
      end
      for (int i = 0; i < BATCH_NB; i++) begin
        if (!bypass && (win == BATCH_W'(i))) begin
          opid_d  = pid_q[i];
          ocmax_d = cmax_q[i];
          oloop_d = icnt_q[i];
        end
      end
    end else if (pcmd_rdy) begin
      vld_d = 1'b0;
    end

    bdone_d    = 1'b0;
    bdone_id_d = loop_done_batch_id;
    ld_hit     = 1'b0;
    ld_load    = 1'b0;
    for (int i = 0; i < BATCH_NB; i++) begin
      st_d[i]   = st_q[i];
      pid_d[i]  = pid_q[i];
      cmax_d[i] = cmax_q[i];
      icnt_d[i] = icnt_q[i];
      dcnt_d[i] = dcnt_q[i];

      if (req_fire && (req_batch_id == BATCH_W'(i))) begin
        st_d[i]   = ST_ISSUE;
        pid_d[i]  = req_first_pid;
        cmax_d[i] = PBS_CNT_W'(req_pbs_nb - 1);
        icnt_d[i] = '0;
        dcnt_d[i] = '0;
      end

      ld_hit  = loop_done && (loop_done_batch_id == BATCH_W'(i));
      ld_load = load && (win == BATCH_W'(i));
      cred_d[i] = cred_q[i] + CRED_W'(ld_hit) - CRED_W'(ld_load);

      if (ld_load) begin
        if (icnt_q[i] == LOOP_W'(BCOL_NB - 1)) begin
          st_d[i]   = ST_DRAIN;
          icnt_d[i] = '0;
        end else begin
          icnt_d[i] = icnt_q[i] + LOOP_W'(1);
        end
      end

      if (ld_hit) begin
        if (dcnt_q[i] == LOOP_W'(BCOL_NB - 1)) begin
          st_d[i]   = ST_IDLE;
          dcnt_d[i] = '0;
          bdone_d   = 1'b1;
        end else begin
          dcnt_d[i] = dcnt_q[i] + LOOP_W'(1);
        end
      end
    end
  end

  // Control state follows both the hard reset and the registered flush;
  // payload registers are qualified by their valids and need no reset.
  always_ff @(posedge clk) begin
    if (!s_rst_n) reset_loop_q <= 1'b0;
    else          reset_loop_q <= reset_cache;

    if (!s_rst_n || reset_loop_q) begin
      vld_q   <= 1'b0;
      bdone_q <= 1'b0;
      rr_q    <= '0;
      for (int i = 0; i < BATCH_NB; i++) begin
        st_q[i]   <= ST_IDLE;
        icnt_q[i] <= '0;
        dcnt_q[i] <= '0;
        cred_q[i] <= CRED_W'(MAX_INFLIGHT);
      end
    end else begin
      vld_q   <= vld_d;
      bdone_q <= bdone_d;
      rr_q    <= rr_d;
      for (int i = 0; i < BATCH_NB; i++) begin
        st_q[i]   <= st_d[i];
        icnt_q[i] <= icnt_d[i];
        dcnt_q[i] <= dcnt_d[i];
        cred_q[i] <= cred_d[i];
      end
    end

    bid_q      <= bid_d;
    opid_q     <= opid_d;
    ocmax_q    <= ocmax_d;
    oloop_q    <= oloop_d;
    bdone_id_q <= bdone_id_d;
    for (int i = 0; i < BATCH_NB; i++) begin
      pid_q[i]  <= pid_d[i];
      cmax_q[i] <= cmax_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst_n && !reset_loop_q) begin
      if (loop_done) begin
        assert (st_q[loop_done_batch_id] != ST_IDLE &&
                cred_q[loop_done_batch_id] != CRED_W'(MAX_INFLIGHT));
      end
      if (req_fire) begin
        assert (req_pbs_nb != '0);
      end
    end
  end

  assign pcmd_vld            = vld_q & ~reset_loop_q;
  assign pcmd_batch_id       = bid_q;
  assign pcmd_batch_id_1h    = BATCH_NB'(1) << bid_q;
  assign pcmd_first_pid      = opid_q;
  assign pcmd_pbs_cnt_max    = ocmax_q;
  assign pcmd_ks_loop        = oloop_q;
  assign batch_done          = bdone_q;
  assign batch_done_batch_id = bdone_id_q;

endmodule

// File: tb/tb_pep_ks_ctrl_loop_sched.sv
// Directed bench for pep_ks_ctrl_loop_sched: credit-paced single batch, refused
// re-request, output stall, flush, and two-slot round-robin interleave.
module tb_pep_ks_ctrl_loop_sched;

  logic       clk;
  logic       s_rst_n;
  logic       reset_cache;
  logic       req_vld;
  logic       req_rdy;
  logic [0:0] req_batch_id;
  logic [5:0] req_first_pid;
  logic [4:0] req_pbs_nb;
  logic       pcmd_vld;
  logic       pcmd_rdy;
  logic [0:0] pcmd_batch_id;
  logic [1:0] pcmd_batch_id_1h;
  logic [5:0] pcmd_first_pid;
  logic [3:0] pcmd_pbs_cnt_max;
  logic [2:0] pcmd_ks_loop;
  logic       loop_done;
  logic [0:0] loop_done_batch_id;
  logic       batch_done;
  logic [0:0] batch_done_batch_id;

  int total = 0;
  int bad   = 0;

  pep_ks_ctrl_loop_sched dut (
    .clk                 (clk),
    .s_rst_n             (s_rst_n),
    .reset_cache         (reset_cache),
    .req_vld             (req_vld),
    .req_rdy             (req_rdy),
    .req_batch_id        (req_batch_id),
    .req_first_pid       (req_first_pid),
    .req_pbs_nb          (req_pbs_nb),
    .pcmd_vld            (pcmd_vld),
    .pcmd_rdy            (pcmd_rdy),
    .pcmd_batch_id       (pcmd_batch_id),
    .pcmd_batch_id_1h    (pcmd_batch_id_1h),
    .pcmd_first_pid      (pcmd_first_pid),
    .pcmd_pbs_cnt_max    (pcmd_pbs_cnt_max),
    .pcmd_ks_loop        (pcmd_ks_loop),
    .loop_done           (loop_done),
    .loop_done_batch_id  (loop_done_batch_id),
    .batch_done          (batch_done),
    .batch_done_batch_id (batch_done_batch_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cmd(input string tag, input int bid, input int lp, input int pid, input int cmax);
    chk({tag, "_vld"},  32'(pcmd_vld), 32'd1);
    chk({tag, "_bid"},  32'(pcmd_batch_id), 32'(bid));
    chk({tag, "_1h"},   32'(pcmd_batch_id_1h), 32'(1 << bid));
    chk({tag, "_loop"}, 32'(pcmd_ks_loop), 32'(lp));
    chk({tag, "_pid"},  32'(pcmd_first_pid), 32'(pid));
    chk({tag, "_cmax"}, 32'(pcmd_pbs_cnt_max), 32'(cmax));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [0:0] id, input logic [5:0] pid, input logic [4:0] nb);
    req_vld       = v;
    req_batch_id  = id;
    req_first_pid = pid;
    req_pbs_nb    = nb;
  endtask

  initial begin
    s_rst_n = 1'b0; reset_cache = 1'b0; pcmd_rdy = 1'b1;
    loop_done = 1'b0; loop_done_batch_id = 1'b0;
    set_req(1'b0, 1'b0, 6'd0, 5'd1);
    #1;
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    tick();
    tick();
    chk("rst_pcmd_vld", 32'(pcmd_vld), 32'd0);
    chk("rst_batch_done", 32'(batch_done), 32'd0);
    chk("rst_req_rdy2", 32'(req_rdy), 32'd0);

    // T0: batch 0 request, pid 60 / nb 4
    tick();
    s_rst_n = 1'b1;
    set_req(1'b1, 1'b0, 6'd60, 5'd4);
    #1;
    chk("t0_req_rdy", 32'(req_rdy), 32'd1);
    chk("t0_pcmd_vld", 32'(pcmd_vld), 32'd0);

    // T1..T25: loop_done returned 4 cycles after each handshake; from T20 a
    // second batch-0 request waits for the slot to drain.
    for (int c = 1; c <= 25; c++) begin
      tick();
      loop_done          = (c >= 5) && (c <= 24) && ((c % 6 == 5) || (c % 6 == 0));
      loop_done_batch_id = 1'b0;
      if (c >= 20) set_req(1'b1, 1'b0, 6'd5, 5'd16);
      else         set_req(1'b0, 1'b0, 6'd0, 5'd1);
      #1;
      if ((c <= 20) && ((c % 6 == 1) || (c % 6 == 2)))
        chk_cmd($sformatf("single_c%0d", c), 0, 2 * (c / 6) + ((c % 6 == 2) ? 1 : 0), 60, 3);
      else
        chk($sformatf("single_idle_c%0d", c), 32'(pcmd_vld), 32'd0);
      chk($sformatf("single_bdone_c%0d", c), 32'(batch_done), 32'(c == 25));
      chk($sformatf("single_rdy_c%0d", c), 32'(req_rdy), 32'(c == 25));
    end
    chk("bdone_id", 32'(batch_done_batch_id), 32'd0);

    // T26..T30: output stalled, first command of the new batch held
    for (int c = 26; c <= 30; c++) begin
      tick();
      loop_done = 1'b0;
      set_req(1'b0, 1'b0, 6'd0, 5'd1);
      pcmd_rdy = 1'b0;
      #1;
      chk_cmd($sformatf("stall_c%0d", c), 0, 0, 5, 15);
      chk($sformatf("stall_bdone_c%0d", c), 32'(batch_done), 32'd0);
    end
    tick(); pcmd_rdy = 1'b1; #1;
    chk_cmd("resume_l0", 0, 0, 5, 15);
    tick(); #1;
    chk_cmd("resume_l1", 0, 1, 5, 15);
    tick(); #1;
    chk("no_credit_vld", 32'(pcmd_vld), 32'd0);
    tick(); loop_done = 1'b1; loop_done_batch_id = 1'b0; #1;
    chk("credit_wait_vld", 32'(pcmd_vld), 32'd0);
    tick(); loop_done = 1'b0; #1;
    chk("credit_back_vld", 32'(pcmd_vld), 32'd0);

    // T36: batch 1 joins while batch 0 is credit-starved
    tick(); set_req(1'b1, 1'b1, 6'd60, 5'd4); #1;
    chk_cmd("resume_l2", 0, 2, 5, 15);
    chk("b1_req_rdy", 32'(req_rdy), 32'd1);
    tick(); set_req(1'b0, 1'b0, 6'd0, 5'd1); reset_cache = 1'b1; #1;
    chk_cmd("b1_l0", 1, 0, 60, 3);

    // Flush: reset_loop high this cycle
    tick(); reset_cache = 1'b0; #1;
    chk("flush_pcmd_vld", 32'(pcmd_vld), 32'd0);
    chk("flush_req_rdy0", 32'(req_rdy), 32'd0);
    req_batch_id = 1'b1; #1;
    chk("flush_req_rdy1", 32'(req_rdy), 32'd0);
    tick(); #1;
    chk("post_flush_vld", 32'(pcmd_vld), 32'd0);
    chk("post_flush_rdy1", 32'(req_rdy), 32'd1);
    req_batch_id = 1'b0; #1;
    chk("post_flush_rdy0", 32'(req_rdy), 32'd1);

    // Consecutive requests on both slots: round-robin interleave
    set_req(1'b1, 1'b0, 6'd60, 5'd4); #1;
    chk("rr_req0_rdy", 32'(req_rdy), 32'd1);
    tick(); set_req(1'b1, 1'b1, 6'd5, 5'd16); #1;
    chk("rr_req1_rdy", 32'(req_rdy), 32'd1);
    chk_cmd("rr_b0_l0", 0, 0, 60, 3);
    tick(); set_req(1'b0, 1'b0, 6'd0, 5'd1); #1;
    chk_cmd("rr_b1_l0", 1, 0, 5, 15);
    chk("rr_b0_busy_rdy", 32'(req_rdy), 32'd0);
    tick(); #1;
    chk_cmd("rr_b0_l1", 0, 1, 60, 3);
    tick(); #1;
    chk_cmd("rr_b1_l1", 1, 1, 5, 15);
    tick(); #1;
    chk("rr_starved_vld", 32'(pcmd_vld), 32'd0);
    chk("rr_bdone", 32'(batch_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
